// File: rtl/hash_job_if.sv
// Host-side job/result channels of the mining-core job controller.
// The host drives jobs in and takes results out through valid/ready pairs.
`timescale 1ns/1ps
interface hash_job_if #(
   parameter int TMO_W = 24
);
   logic             job_valid;
   logic             job_ready;
   logic [95:0]      job_payload;
   logic [7:0]       job_target;
   logic             res_valid;
   logic             res_ready;
   logic [31:0]      res_nonce;
   logic [23:0]      res_hash;
   logic [1:0]       res_status;
   logic [TMO_W-1:0] res_cycles;

   modport master (
      output job_valid, job_payload, job_target, res_ready,
      input  job_ready, res_valid, res_nonce, res_hash, res_status, res_cycles
   );

   modport slave (
      input  job_valid, job_payload, job_target, res_ready,
      output job_ready, res_valid, res_nonce, res_hash, res_status, res_cycles
   );
endinterface

// File: rtl/hash_job_ctrl.sv
// Initiator side of the mining-core job interface: runs one job at a time on the
// core, re-checks the returned hash against the target and reports one result.
`timescale 1ns/1ps
module hash_job_ctrl #(
   parameter int               TMO_W   = 24,
   parameter logic [TMO_W-1:0] TMO_MAX = {TMO_W{1'b1}}
) (
   input  logic        clk,
   input  logic        rst_n,
   hash_job_if.slave   host,
   output logic        core_active,
   output logic [95:0] core_payload,
   output logic [7:0]  core_target,
   input  logic        core_terminado,
   input  logic [31:0] core_nonce,
   input  logic [23:0] core_hash
);

   typedef enum logic [1:0] {IDLE, CLEAR, RUN, RESP} state_t;
   typedef enum logic [1:0] {ST_OK = 2'b00, ST_BAD = 2'b01, ST_TMO = 2'b10} status_t;

   state_t           state, next_state;
   logic [TMO_W-1:0] counter;
   logic             take_job;
   logic             timeout;
   logic             hash_ok;

   assign host.job_ready = (state == IDLE);
   assign host.res_valid = (state == RESP);

   always_comb begin
      // NOTE: every output of this block gets a default before the case, so no path can infer a latch.
      next_state = state;
      take_job   = host.job_valid && (state == IDLE);
      timeout    = (counter == TMO_MAX);
      hash_ok    = (core_hash[23:16] < core_target) && (core_hash[15:8] < core_target);
      case (state)
         IDLE:    if (take_job) next_state = CLEAR;
         // terminado may still be high from the previous job, so CLEAR never looks at it
         CLEAR:   next_state = RUN;
         RUN:     if (core_terminado || timeout) next_state = RESP;
         RESP:    if (host.res_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         core_active     <= 1'b0;
         core_payload    <= '0;
         core_target     <= '0;
         counter         <= '0;
         host.res_nonce  <= '0;
         host.res_hash   <= '0;
         host.res_status <= '0;
         host.res_cycles <= '0;
      end else begin
         core_active <= (next_state == RUN);

         // The counter counts the edge into RUN, so it reads 1 on the first RUN cycle
         if (take_job) begin
            core_payload <= host.job_payload;
            core_target  <= host.job_target;
            counter      <= '0;
         end else if (next_state == RUN) begin
            counter <= counter + TMO_W'(1);
         end

         if (state == RUN && core_terminado) begin
            host.res_nonce  <= core_nonce;
            host.res_hash   <= core_hash;
            host.res_status <= hash_ok ? ST_OK : ST_BAD;
            host.res_cycles <= counter;
         end else if (state == RUN && timeout) begin
            host.res_nonce  <= '0;
            host.res_hash   <= '0;
            host.res_status <= ST_TMO;
            host.res_cycles <= TMO_MAX;
         end
      end
   end

endmodule
